// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared codes, decode constants and FSM state type for the ALU controller
package alu_ctrl_pkg;

    // ALU control codes (5-bit native, zero-extended to CTRL_W at use sites)
    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_AND   = 5'd3;
    localparam logic [4:0] ALU_OR    = 5'd4;
    localparam logic [4:0] ALU_SLT   = 5'd5;
    localparam logic [4:0] ALU_SLTU  = 5'd6;
    localparam logic [4:0] ALU_SLL   = 5'd7;
    localparam logic [4:0] ALU_SLLV  = 5'd8;
    localparam logic [4:0] ALU_NOR   = 5'd9;
    localparam logic [4:0] ALU_XOR   = 5'd10;
    localparam logic [4:0] ALU_ORI   = 5'd11;
    localparam logic [4:0] ALU_LUI   = 5'd12;
    localparam logic [4:0] ALU_SRL   = 5'd13;
    localparam logic [4:0] ALU_SRLV  = 5'd14;
    localparam logic [4:0] ALU_BEQ   = 5'd15;
    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;
    localparam logic [4:0] ALU_MFHI  = 5'd20;
    localparam logic [4:0] ALU_MFLO  = 5'd21;

    // Main-control ALUOp classes
    localparam logic [2:0] ALUOP_NOP   = 3'b000;
    localparam logic [2:0] ALUOP_BEQ   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_SLTI  = 3'b011;
    localparam logic [2:0] ALUOP_ANDI  = 3'b100;
    localparam logic [2:0] ALUOP_ADDI  = 3'b101;
    localparam logic [2:0] ALUOP_ORI   = 3'b110;
    localparam logic [2:0] ALUOP_LUI   = 3'b111;

    // R-type funct values
    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SLLV  = 6'd4;
    localparam logic [5:0] FN_SRLV  = 6'd6;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    // MDU operation codes; bit 1 set means a divide
    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// rtl/alu_ctrl_dec.sv - combinational ALUOp/funct decoder to control word, MDU flags and illegal flag
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 3,
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 5
)(
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               is_mdu,
    output logic [1:0]         mdu_op,
    output logic               illegal
);

    logic [4:0] code;

    // Map the operation class, then the funct field for R-type, onto a control code
    always_comb begin
        code    = ALU_NOP;
        is_mdu  = 1'b0;
        mdu_op  = MDU_MULT;
        illegal = 1'b0;
        case (alu_op)
            OP_W'(ALUOP_NOP):  code = ALU_NOP;
            OP_W'(ALUOP_BEQ):  code = ALU_BEQ;
            OP_W'(ALUOP_SLTI): code = ALU_SLT;
            OP_W'(ALUOP_ANDI): code = ALU_AND;
            OP_W'(ALUOP_ADDI): code = ALU_ADD;
            OP_W'(ALUOP_ORI):  code = ALU_ORI;
            OP_W'(ALUOP_LUI):  code = ALU_LUI;
            OP_W'(ALUOP_RTYPE): begin
                case (funct)
                    FUNCT_W'(FN_ADD):   code = ALU_ADD;
                    FUNCT_W'(FN_SUB):   code = ALU_SUB;
                    FUNCT_W'(FN_AND):   code = ALU_AND;
                    FUNCT_W'(FN_OR):    code = ALU_OR;
                    FUNCT_W'(FN_XOR):   code = ALU_XOR;
                    FUNCT_W'(FN_NOR):   code = ALU_NOR;
                    FUNCT_W'(FN_SLT):   code = ALU_SLT;
                    FUNCT_W'(FN_SLTU):  code = ALU_SLTU;
                    FUNCT_W'(FN_SLL):   code = ALU_SLL;
                    FUNCT_W'(FN_SRL):   code = ALU_SRL;
                    FUNCT_W'(FN_SLLV):  code = ALU_SLLV;
                    FUNCT_W'(FN_SRLV):  code = ALU_SRLV;
                    FUNCT_W'(FN_MFHI):  code = ALU_MFHI;
                    FUNCT_W'(FN_MFLO):  code = ALU_MFLO;
                    FUNCT_W'(FN_MULT):  begin code = ALU_MULT;  is_mdu = 1'b1; mdu_op = MDU_MULT;  end
                    FUNCT_W'(FN_MULTU): begin code = ALU_MULTU; is_mdu = 1'b1; mdu_op = MDU_MULTU; end
                    FUNCT_W'(FN_DIV):   begin code = ALU_DIV;   is_mdu = 1'b1; mdu_op = MDU_DIV;   end
                    FUNCT_W'(FN_DIVU):  begin code = ALU_DIVU;  is_mdu = 1'b1; mdu_op = MDU_DIVU;  end
                    default:            begin code = ALU_NOP;   illegal = 1'b1; end
                endcase
            end
            default: code = ALU_NOP;
        endcase
    end

    assign ctrl = CTRL_W'(code);

endmodule

// File: rtl/alu_ctrl_mdu.sv
// rtl/alu_ctrl_mdu.sv - registered ALU control word with multiply/divide sequencing and stall
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W       = 3,
    parameter int FUNCT_W    = 6,
    parameter int CTRL_W     = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
)(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               flush_i,
    input  logic [OP_W-1:0]    ALUOp_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               busy_o,
    output logic               mdu_start_o,
    output logic [1:0]         mdu_op_o,
    output logic               hilo_we_o,
    output logic               illegal_o
);

    localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               start_q, start_d;
    logic [1:0]         op_q, op_d;
    logic               illegal_q, illegal_d;

    logic [CTRL_W-1:0]  dec_ctrl;
    logic               dec_is_mdu;
    logic [1:0]         dec_mdu_op;
    logic               dec_illegal;
    logic               accept;

    alu_ctrl_dec #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W),
        .CTRL_W  (CTRL_W)
    ) u_dec (
        .alu_op  (ALUOp_i),
        .funct   (funct_i),
        .ctrl    (dec_ctrl),
        .is_mdu  (dec_is_mdu),
        .mdu_op  (dec_mdu_op),
        .illegal (dec_illegal)
    );

    assign busy_o    = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign hilo_we_o = (state_q == ST_DONE);
    assign accept    = valid_i && !busy_o && !flush_i;

    // State, counter and output registers; reset forces NOP/IDLE at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            start_q   <= 1'b0;
            op_q      <= MDU_MULT;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            start_q   <= start_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state: accept in IDLE/DONE, count down while busy, flush aborts a running op
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        start_d   = 1'b0;
        op_d      = op_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_MUL, ST_DIV: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ctrl_d  = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctrl_d  = '0;
                if (accept) begin
                    ctrl_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                    if (dec_is_mdu) begin
                        start_d = 1'b1;
                        op_d    = dec_mdu_op;
                        if (dec_mdu_op[1]) begin
                            state_d = ST_DIV;
                            cnt_d   = DIV_LOAD;
                        end else begin
                            state_d = ST_MUL;
                            cnt_d   = MUL_LOAD;
                        end
                    end
                end
            end
        endcase
    end

    assign ALUCtrl_o   = ctrl_q;
    assign mdu_start_o = start_q;
    assign mdu_op_o    = op_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb/tb_alu_ctrl_mdu.sv - randomized and directed bench for alu_ctrl_mdu against a cycle-count model
module tb_alu_ctrl_mdu;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] alu_op = 3'd0;
    logic [5:0] funct = 6'd0;
    logic [4:0] alu_ctrl;
    logic       busy;
    logic       mdu_start;
    logic [1:0] mdu_op;
    logic       hilo_we;
    logic       illegal;

    int errs = 0;
    int checks = 0;

    // Reference tables straight from the encoding lists; -1 means "look further" / undefined
    int opcode [8] = '{0, 15, -1, 5, 3, 1, 11, 12};
    int fcode  [64];
    int legal_fn [18] = '{32, 34, 36, 37, 38, 39, 42, 43, 0, 2, 4, 6, 16, 18, 24, 25, 26, 27};

    // Model: remaining busy cycles plus the expected visible outputs
    int m_busy_left = 0;
    int m_ctrl = 0;
    int m_start = 0;
    int m_op = 0;
    int m_hilo = 0;
    int m_ill = 0;

    alu_ctrl_mdu #(
        .OP_W       (3),
        .FUNCT_W    (6),
        .CTRL_W     (5),
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .flush_i     (flush),
        .ALUOp_i     (alu_op),
        .funct_i     (funct),
        .ALUCtrl_o   (alu_ctrl),
        .busy_o      (busy),
        .mdu_start_o (mdu_start),
        .mdu_op_o    (mdu_op),
        .hilo_we_o   (hilo_we),
        .illegal_o   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("alu_ctrl", 32'(alu_ctrl), m_ctrl);
        chk("busy", 32'(busy), (m_busy_left > 0) ? 1 : 0);
        chk("mdu_start", 32'(mdu_start), m_start);
        chk("mdu_op", 32'(mdu_op), m_op);
        chk("hilo_we", 32'(hilo_we), m_hilo);
        chk("illegal", 32'(illegal), m_ill);
    endtask

    task automatic model_reset();
        m_busy_left = 0; m_ctrl = 0; m_start = 0; m_op = 0; m_hilo = 0; m_ill = 0;
    endtask

    task automatic model_edge(input logic v, input logic fl, input int op, input int fn);
        int c;
        m_start = 0;
        m_ill   = 0;
        if (m_busy_left > 0) begin
            m_hilo = 0;
            if (fl) begin
                m_busy_left = 0;
                m_ctrl = 0;
            end else begin
                m_busy_left--;
                if (m_busy_left == 0) m_hilo = 1;
            end
        end else begin
            m_hilo = 0;
            m_ctrl = 0;
            if (v && !fl) begin
                c = opcode[op];
                if (c < 0) c = fcode[fn];
                if (c < 0) begin
                    m_ill = 1;
                end else begin
                    m_ctrl = c;
                    if (c >= 16 && c <= 19) begin
                        m_start = 1;
                        m_op = c - 16;
                        m_busy_left = (c >= 18) ? DIV_N : MUL_N;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic fl, input int op, input int fn);
        valid  = v;
        flush  = fl;
        alu_op = op[2:0];
        funct  = fn[5:0];
        @(posedge clk);
        model_edge(v, fl, op, fn);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        foreach (fcode[i]) fcode[i] = -1;
        fcode[32] = 1;  fcode[34] = 2;  fcode[36] = 3;  fcode[37] = 4;
        fcode[38] = 10; fcode[39] = 9;  fcode[42] = 5;  fcode[43] = 6;
        fcode[0]  = 7;  fcode[2]  = 13; fcode[4]  = 8;  fcode[6]  = 14;
        fcode[16] = 20; fcode[18] = 21; fcode[24] = 16; fcode[25] = 17;
        fcode[26] = 18; fcode[27] = 19;

        // Power-on reset
        #2 rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Simple R-type ops back to back
        step(1'b1, 1'b0, 2, 32);
        step(1'b1, 1'b0, 2, 34);
        step(1'b1, 1'b0, 2, 39);
        step(1'b1, 1'b0, 2, 2);
        idle(2);

        // Multiply: full occupancy then one write strobe
        step(1'b1, 1'b0, 2, 24);
        idle(MUL_N + 2);

        // divu, then mult held on valid so it is taken in the DONE cycle
        step(1'b1, 1'b0, 2, 27);
        for (int i = 0; i < DIV_N + 2; i++) step(1'b1, 1'b0, 2, 24);
        idle(MUL_N + 2);

        // div flushed on its 5th busy cycle: no write strobe afterwards
        step(1'b1, 1'b0, 2, 26);
        idle(4);
        step(1'b0, 1'b1, 0, 0);
        idle(DIV_N + 2);

        // Undefined funct, ori class, beq class
        step(1'b1, 1'b0, 2, 63);
        step(1'b1, 1'b0, 6, 0);
        step(1'b1, 1'b0, 1, 0);
        idle(1);

        // Asynchronous reset in the middle of a divide
        step(1'b1, 1'b0, 2, 26);
        idle(9);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        idle(DIV_N + 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int op;
            int fn;
            logic v;
            logic fl;
            v  = ($urandom_range(0, 9) < 8);
            fl = ($urandom_range(0, 24) == 0);
            op = int'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) op = 2;
            if ($urandom_range(0, 5) == 0) fn = int'($urandom_range(0, 63));
            else fn = legal_fn[$urandom_range(0, 17)];
            step(v, fl, op, fn);
        end
        idle(DIV_N + 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
- Next-generation ALU controller for the pipelined MIPS core, placed in the ID/EX boundary.
- Decodes ALUOp/funct into a registered ALU control word with a widened encoding, adding nor, xor, srl, srlv and the HI/LO group.
- Sequences multi-cycle multiply/divide operations with a busy/stall handshake and a HI/LO write strobe.

Parameters:
- OP_W, 3, ALUOp width.
- FUNCT_W, 6, funct field width.
- CTRL_W, 5, ALU control word width (minimum 5).
- MUL_CYCLES, 4, multiply occupancy in cycles (minimum 2).
- DIV_CYCLES, 32, divide occupancy in cycles (minimum 2).

Ports:
- clk_i  in  1  single clock for the block.
- rst_i  in  1  asynchronous reset, active-high.
- valid_i  in  1  a decoded instruction is presented this cycle.
- flush_i  in  1  synchronous pipeline flush.
- ALUOp_i  in  OP_W  main-control ALU operation class.
- funct_i  in  FUNCT_W  R-type funct field.
- ALUCtrl_o  out  CTRL_W  registered ALU control word to EX.
- busy_o  out  1  stall request to the hazard unit.
- mdu_start_o  out  1  one-cycle start pulse to the multiply/divide datapath.
- mdu_op_o  out  2  MDU operation: 0 mult, 1 multu, 2 div, 3 divu.
- hilo_we_o  out  1  one-cycle HI/LO write enable.
- illegal_o  out  1  registered flag: undefined funct seen.

Behaviour:
- Reset (asynchronous, any state): ALUCtrl_o=0 (NOP), busy_o=0, mdu_start_o=0, mdu_op_o=0, hilo_we_o=0, illegal_o=0, FSM=IDLE, counter=0.
- Encoding (zero-extended to CTRL_W): NOP 0, add 1, sub 2, and 3, or 4, slt 5, sltu 6, sll 7, sllv 8, nor 9, xor 10, ori 11, lui 12, srl 13, srlv 14, beq 15, mult 16, multu 17, div 18, divu 19, mfhi 20, mflo 21.
- ALUOp decode: 000→NOP; 001→beq; 010→R-type funct decode; 011→slt (slti); 100→and (andi); 101→add (addi/lw/sw); 110→ori; 111→lui.
- Funct decode (ALUOp=010): 32 add, 34 sub, 36 and, 37 or, 38 xor, 39 nor, 42 slt, 43 sltu, 0 sll, 2 srl, 4 sllv, 6 srlv, 16 mfhi, 18 mflo, 24 mult, 25 multu, 26 div, 27 divu.
- Any other funct: ALUCtrl_o←NOP and illegal_o←1 for one cycle.
- Latency: accepted instruction updates ALUCtrl_o one clock later.
- Acceptance condition: valid_i & ~busy_o & ~flush_i.
- valid_i=0 or flush_i=1 in IDLE/DONE: ALUCtrl_o←NOP at the next edge.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE/DONE, accepted funct 24/25: →MUL, counter←MUL_CYCLES-1, mdu_start_o=1 next cycle, mdu_op_o latched.
- IDLE/DONE, accepted funct 26/27: →DIV, counter←DIV_CYCLES-1, mdu_start_o=1 next cycle, mdu_op_o latched.
- IDLE/DONE, any other accepted instruction: →IDLE (DONE also returns to IDLE when nothing is accepted).
- MUL/DIV: busy_o=1 (decoded from state). Counter decrements each cycle; at counter=0 →DONE. valid_i is ignored; upstream holds the instruction.
- DONE: hilo_we_o=1 for exactly one cycle, busy_o=0. A new instruction may be accepted in the same cycle, so back-to-back MDU operations are allowed.
- Total occupancy: busy_o is high for N cycles (N = MUL_CYCLES or DIV_CYCLES), starting the cycle after acceptance.
- ALUCtrl_o during MUL/DIV/DONE: holds the MDU code.
- flush_i in MUL/DIV: abort →IDLE at the next edge, no hilo_we_o, ALUCtrl_o←NOP. flush_i has priority over counter expiry in the same cycle.
- flush_i in DONE: hilo_we_o still asserts (the result is complete); no new acceptance.
- mfhi/mflo issued directly after DONE: legal, because HI/LO is written in the DONE cycle.
- Reset mid-operation: immediate return to IDLE; no hilo_we_o.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU control code constants (all codes above).
  - ALUOp constants.
  - Funct constants.
  - FSM state enum.
  - MDU op codes.
- Sub-module alu_ctrl_dec: purely combinational ALUOp/funct→{ctrl, is_mdu, mdu_op, illegal} decoder.
- Top level holds the registers, FSM and counter.

Test Plan:
- Reset mid-DIV (rst_i pulsed at cycle 10, async between edges) → all outputs 0 immediately, FSM IDLE, no hilo_we_o afterwards.
- ALUOp=010, funct 32,34,39,2 on consecutive valid cycles → ALUCtrl_o = 1,2,9,13, each one cycle later; busy_o stays 0.
- ALUOp=010, funct 24 (MUL_CYCLES=4) → mdu_start_o at t+1, mdu_op_o=0, busy_o high t+1..t+4, hilo_we_o at t+5 only, ALUCtrl_o=16 held.
- divu followed immediately by mult held on valid_i → second accepted in the DONE cycle (hilo_we_o=1 same cycle), busy_o re-asserts the next cycle, mdu_op_o 3→0.
- div with flush_i at its 5th busy cycle → FSM IDLE next edge, no hilo_we_o ever, ALUCtrl_o=0.
- ALUOp=010, funct 63 → ALUCtrl_o=0 and illegal_o=1 for one cycle. ALUOp=110 → ALUCtrl_o=11; ALUOp=001 → 15.
